// File: rtl/muldiv_ctrl.sv
// HI/LO register file and sequencer for an iterative multiply/divide execution unit.
// MTHI/MTLO, multiply-by-zero and divide-by-zero finish in IDLE; everything else goes through WAIT.
module muldiv_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        op_ready,
    input  logic        flush,
    input  logic        mf_req,
    input  logic        mf_sel,
    output logic [31:0] mf_data,
    output logic        stall,
    output logic        eu_start,
    output logic        eu_is_div,
    output logic        eu_signed,
    output logic [31:0] eu_a,
    output logic [31:0] eu_b,
    output logic        eu_abort,
    input  logic        eu_done,
    input  logic [31:0] eu_hi,
    input  logic [31:0] eu_lo,
    output logic        timeout_err
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    // Counter is cleared on entry, so it holds k-1 during the k-th WAIT cycle.
    localparam logic [5:0] CNT_LIMIT = 6'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [31:0] hi_reg;
    logic [31:0] hi_next;
    logic [31:0] lo_reg;
    logic [31:0] lo_next;
    logic [5:0]  cnt_reg;
    logic [5:0]  cnt_next;
    logic        start_pend_reg;
    logic        terr_reg;
    logic [31:0] eu_a_reg;
    logic [31:0] eu_b_reg;
    logic        eu_is_div_reg;
    logic        eu_signed_reg;

    logic        op_reserved;
    logic        op_is_mul;
    logic        op_is_div;
    logic        op_accept;
    logic        mul_trivial;
    logic        div_by_zero;
    logic        launch;

    logic        in_wait;
    logic        wait_flush;
    logic        wait_done;
    logic        wait_timeout;

    // Operation decode and acceptance
    always_comb begin
        op_reserved = (op_code[2:1] == 2'b11);
        op_is_mul   = (op_code == OP_MULT) || (op_code == OP_MULTU);
        op_is_div   = (op_code == OP_DIV) || (op_code == OP_DIVU);
        op_accept   = op_valid && (state_reg == ST_IDLE) && !flush && !op_reserved;
        mul_trivial = op_is_mul && ((op_a == 32'd0) || (op_b == 32'd0));
        div_by_zero = op_is_div && (op_b == 32'd0);
        launch      = op_accept && (op_is_mul || op_is_div) && !mul_trivial && !div_by_zero;
    end

    // WAIT exit causes; flush has priority over both completion and timeout
    always_comb begin
        in_wait      = (state_reg == ST_WAIT);
        wait_flush   = in_wait && flush;
        wait_done    = in_wait && !flush && eu_done;
        wait_timeout = in_wait && !flush && !eu_done && (cnt_reg == CNT_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (launch) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_flush || wait_done || wait_timeout) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready    = (state_reg == ST_IDLE);
        stall       = in_wait && (mf_req || (op_valid && !op_reserved));
        eu_abort    = wait_flush || wait_timeout;
        eu_start    = in_wait && start_pend_reg && !eu_abort;
        mf_data     = mf_sel ? hi_reg : lo_reg;
        eu_a        = eu_a_reg;
        eu_b        = eu_b_reg;
        eu_is_div   = eu_is_div_reg;
        eu_signed   = eu_signed_reg;
        timeout_err = terr_reg;
    end

    // HI/LO update: IDLE-completed ops or a clean unit result
    always_comb begin
        hi_next = hi_reg;
        lo_next = lo_reg;
        if (op_accept) begin
            case (op_code)
                OP_MTHI: hi_next = op_a;
                OP_MTLO: lo_next = op_a;
                OP_MULT, OP_MULTU: begin
                    if (mul_trivial) begin
                        hi_next = 32'd0;
                        lo_next = 32'd0;
                    end
                end
                default: begin
                    hi_next = hi_reg;
                    lo_next = lo_reg;
                end
            endcase
        end else if (wait_done) begin
            hi_next = eu_hi;
            lo_next = eu_lo;
        end
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (launch) begin
            cnt_next = 6'd0;
        end else if (in_wait) begin
            cnt_next = cnt_reg + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_reg         <= 32'd0;
            lo_reg         <= 32'd0;
            cnt_reg        <= 6'd0;
            start_pend_reg <= 1'b0;
            terr_reg       <= 1'b0;
            eu_a_reg       <= 32'd0;
            eu_b_reg       <= 32'd0;
            eu_is_div_reg  <= 1'b0;
            eu_signed_reg  <= 1'b0;
        end else begin
            hi_reg         <= hi_next;
            lo_reg         <= lo_next;
            cnt_reg        <= cnt_next;
            start_pend_reg <= launch;
            if (wait_timeout) begin
                terr_reg <= 1'b1;
            end
            // Operands stay frozen for the whole WAIT; only a new launch reloads them.
            if (launch) begin
                eu_a_reg      <= op_a;
                eu_b_reg      <= op_b;
                eu_is_div_reg <= op_is_div;
                eu_signed_reg <= ~op_code[0];
            end
        end
    end

    a_start_abort_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(eu_start && eu_abort));

    a_start_single: assert property (@(posedge clk) disable iff (!rst_n)
        eu_start |=> !eu_start);

endmodule
